// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the NCO increment used by both
// directions so TX and RX agree on one bit-period definition.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_tx_state_t;

  // round(baud * oversample * 2^acc_width / clk_hz), all in 64-bit arithmetic
  function automatic longint unsigned nco_incr(input longint unsigned clk_hz,
                                               input longint unsigned baud,
                                               input longint unsigned oversample,
                                               input int unsigned     acc_width);
    longint unsigned num;
    num = baud * oversample * (64'd1 << acc_width);
    return (num + clk_hz / 64'd2) / clk_hz;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; reset flushes the contents.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH) + 1;

  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + PtrW'(1);
      if (pop_i)  rptr_q <= rptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[PtrW-2:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q[PtrW-2:0]];
  assign level_o = wptr_q - rptr_q;
  assign empty_o = (wptr_q == rptr_q);
  // Same slot index but different lap means the writer is a full lap ahead.
  assign full_o  = (wptr_q[PtrW-1] != rptr_q[PtrW-1]) &&
                   (wptr_q[PtrW-2:0] == rptr_q[PtrW-2:0]);

endmodule

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter: byte FIFO feeding a framing FSM paced by a fractional NCO
// that produces OVERSAMPLE ticks per bit period.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam longint unsigned IncrL = nco_incr(CLK_HZ, BAUD, OVERSAMPLE, ACC_WIDTH);
  localparam logic [ACC_WIDTH:0] Incr = (ACC_WIDTH + 1)'(IncrL);
  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] LastTick = TickW'(OVERSAMPLE - 1);

  if (IncrL > (64'd1 << ACC_WIDTH)) begin : g_incr_too_large
    $error("uart_tx: NCO increment exceeds 2^ACC_WIDTH");
  end

  if (OVERSAMPLE < 4 || (OVERSAMPLE & (OVERSAMPLE - 1)) != 0) begin : g_bad_oversample
    $error("uart_tx: OVERSAMPLE must be a power of two >= 4");
  end

  // NCO
  logic [ACC_WIDTH:0] phase_q, phase_next;
  logic               os_tick_q;

  assign phase_next = phase_q + Incr;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q   <= '0;
      os_tick_q <= 1'b0;
    end else begin
      phase_q   <= {1'b0, phase_next[ACC_WIDTH-1:0]};
      os_tick_q <= phase_next[ACC_WIDTH];
    end
  end

  // FIFO
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  assign s_ready   = !fifo_full;
  assign fifo_push = s_valid && s_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (s_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Framing FSM
  uart_tx_state_t   state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tick_d   = tick_q;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    tx_d     = tx_q;
    fifo_pop = 1'b0;
    if (os_tick_q) begin
      unique case (state_q)
        StIdle: begin
          tx_d = 1'b1;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shreg_d  = fifo_rdata;
            tx_d     = 1'b0;
            tick_d   = '0;
            state_d  = StStart;
          end
        end
        StStart: begin
          if (tick_q == LastTick) begin
            tx_d    = shreg_q[0];
            bit_d   = '0;
            tick_d  = '0;
            state_d = StData;
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StData: begin
          if (tick_q == LastTick) begin
            shreg_d = shreg_q >> 1;
            tick_d  = '0;
            if (bit_q == 3'd7) begin
              tx_d    = 1'b1;
              state_d = StStop;
            end else begin
              tx_d  = shreg_q[1];
              bit_d = bit_q + 3'd1;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        StStop: begin
          if (tick_q == LastTick) begin
            tick_d = '0;
            // A queued byte starts immediately, with no idle gap after the stop bit.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shreg_d  = fifo_rdata;
              tx_d     = 1'b0;
              state_d  = StStart;
            end else begin
              state_d = StIdle;
            end
          end else begin
            tick_d = tick_q + TickW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign tx_o = tx_q;
  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: line capture decoded into frames and compared against
// the bytes pushed, plus flow-control and reset scenarios.
module tb_uart_tx;

  localparam int unsigned OS       = 16;
  localparam int unsigned FrameLen = 10 * OS;
  localparam int unsigned Depth    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic       tx_o;
  logic       busy;
  logic [4:0] fifo_level;

  int checks = 0;
  int errors = 0;

  // One os_tick per clock: 1.6 MHz / (100 kbaud * 16).
  uart_tx #(
    .CLK_HZ     (1_600_000),
    .BAUD       (100_000),
    .OVERSAMPLE (OS),
    .ACC_WIDTH  (24),
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .tx_o       (tx_o),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Line capture, one sample per clock
  logic       cap_en = 1'b0;
  logic       line_q[$];
  logic       busy_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         glitch;

  always @(negedge clk) begin
    if (cap_en) begin
      line_q.push_back(tx_o);
      busy_q.push_back(busy);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst     = 1'b1;
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic start_capture();
    line_q.delete();
    busy_q.delete();
    cap_en = 1'b1;
  endtask

  // Drives one byte at the current negedge; returns one negedge later.
  task automatic push_byte(input logic [7:0] b);
    int guard = 0;
    while (!s_ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    s_valid = 1'b1;
    s_data  = b;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((fifo_level != 0 || busy) && guard < 20000);
    checks++;
    if (fifo_level !== 5'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: level=%0d busy=%b after %0d cycles, required level=0 busy=0",
               fifo_level, busy, guard);
    end
    repeat (20) @(negedge clk);
    cap_en = 1'b0;
  endtask

  // Splits the captured line into frames; every bit must hold for OS samples with busy high,
  // idle samples must have busy low, and start/stop levels must be 0/1.
  task automatic decode_line();
    int         pos  = 0;
    bit         done = 1'b0;
    logic [9:0] bits;
    rx_q.delete();
    start_q.delete();
    glitch = 0;
    while (!done) begin
      while (pos < line_q.size() && line_q[pos] === 1'b1) begin
        if (busy_q[pos] !== 1'b0) glitch++;
        pos++;
      end
      if (pos >= line_q.size()) begin
        done = 1'b1;
      end else if (pos + int'(FrameLen) > line_q.size()) begin
        glitch++;
        done = 1'b1;
      end else begin
        start_q.push_back(pos);
        for (int k = 0; k < 10; k++) begin
          bits[k] = line_q[pos + k * OS];
          for (int j = 0; j < OS; j++) begin
            if (line_q[pos + k * OS + j] !== bits[k] || busy_q[pos + k * OS + j] !== 1'b1)
              glitch++;
          end
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) glitch++;
        rx_q.push_back(bits[8:1]);
        pos += FrameLen;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, required 1", tx_o); end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", s_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++;
    if (fifo_level !== 5'd0) begin
      errors++;
      $display("FAIL reset_level: got %0d, required 0", fifo_level);
    end
  endtask

  task automatic test_idle();
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_line: %0d cycles with tx_o!=1 or busy!=0, required 0", bad);
    end
  endtask

  task automatic test_single_55();
    start_capture();
    push_byte(8'h55);
    checks++;
    if (tx_o !== 1'b1) begin
      errors++;
      $display("FAIL latency_early: tx_o=%b one cycle after push, required 1", tx_o);
    end
    @(negedge clk);
    checks++;
    if (tx_o !== 1'b0) begin
      errors++;
      $display("FAIL latency_start: tx_o=%b two cycles after push, required 0", tx_o);
    end
    wait_idle();
    decode_line();
    checks++;
    if (rx_q.size() != 1) begin
      errors++;
      $display("FAIL single_count: got %0d frames, required 1", rx_q.size());
    end
    if (rx_q.size() >= 1) begin
      checks++;
      if (rx_q[0] !== 8'h55) begin
        errors++;
        $display("FAIL single_data: got %02h, required 55", rx_q[0]);
      end
    end
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL single_timing: %0d bad samples, required 0", glitch);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[3];
    bytes[0] = 8'hA3;
    bytes[1] = 8'h0F;
    bytes[2] = 8'hFF;
    start_capture();
    for (int i = 0; i < 3; i++) push_byte(bytes[i]);
    wait_idle();
    decode_line();
    checks++;
    if (rx_q.size() != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d frames, required 3", rx_q.size());
    end
    for (int i = 0; i < 3 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== bytes[i]) begin
        errors++;
        $display("FAIL b2b_data[%0d]: got %02h, required %02h", i, rx_q[i], bytes[i]);
      end
    end
    for (int i = 1; i < start_q.size(); i++) begin
      checks++;
      if (start_q[i] != start_q[i-1] + int'(FrameLen)) begin
        errors++;
        $display("FAIL b2b_gap[%0d]: frame start at %0d, required %0d", i, start_q[i],
                 start_q[i-1] + int'(FrameLen));
      end
    end
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL b2b_timing: %0d bad samples, required 0", glitch);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    exp_q.delete();
    start_capture();
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 250)) @(negedge clk);
      b = 8'($urandom);
      exp_q.push_back(b);
      push_byte(b);
    end
    wait_idle();
    decode_line();
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d frames, required %0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %02h, required %02h", i, rx_q[i], exp_q[i]);
      end
    end
    checks++;
    if (glitch != 0) begin
      errors++;
      $display("FAIL rand_timing: %0d bad samples, required 0", glitch);
    end
  endtask

  // Depth bytes queued plus one in flight; one more slot opens when the first frame ends.
  task automatic test_flow_control();
    int acc = 0;
    apply_reset();
    s_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (s_ready) acc++;
      s_data = 8'($urandom);
      @(negedge clk);
      if (i == 99) begin
        checks++;
        if (acc != Depth + 1) begin
          errors++;
          $display("FAIL flow_accepted_early: got %0d, required %0d", acc, Depth + 1);
        end
        checks++;
        if (fifo_level !== 5'(Depth) || s_ready !== 1'b0) begin
          errors++;
          $display("FAIL flow_full: level=%0d ready=%b, required level=%0d ready=0",
                   fifo_level, s_ready, Depth);
        end
      end
    end
    s_valid = 1'b0;
    checks++;
    if (acc != Depth + 2) begin
      errors++;
      $display("FAIL flow_accepted_late: got %0d, required %0d", acc, Depth + 2);
    end
    checks++;
    if (fifo_level !== 5'(Depth) || s_ready !== 1'b0) begin
      errors++;
      $display("FAIL flow_refull: level=%0d ready=%b, required level=%0d ready=0",
               fifo_level, s_ready, Depth);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad = 0;
    apply_reset();
    push_byte(8'h00);
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    // Start bit began two samples ago; advance to the middle of data bit 4.
    checks++;
    if (tx_o !== 1'b0 || fifo_level !== 5'd3) begin
      errors++;
      $display("FAIL midrst_pre: tx=%b level=%0d, required tx=0 level=3", tx_o, fifo_level);
    end
    repeat (5 * OS + OS / 2 - 2) @(negedge clk);
    checks++;
    if (tx_o !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL midrst_bit4: tx=%b busy=%b, required tx=0 busy=1", tx_o, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (tx_o !== 1'b1 || fifo_level !== 5'd0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_after: tx=%b level=%0d busy=%b ready=%b, required 1/0/0/1",
               tx_o, fifo_level, busy, s_ready);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL midrst_quiet: %0d non-idle cycles after reset, required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_single_55();
    test_back_to_back();
    test_random();
    test_flow_control();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
